// File: rtl/prince_round_ctrl_pkg.sv
// Shared definitions for the Prince round-sequencing controller.
//   state_e          : controller phases IDLE / FWD / MID / BWD
//   SEL_FWD/MID/BWD  : values driven on the datapath phase select `s`
//   cnt_width()      : width of the round index for a given highest index R
package prince_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    MID  = 2'd2,
    BWD  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_FWD = 2'b11;
  localparam logic [1:0] SEL_MID = 2'b10;
  localparam logic [1:0] SEL_BWD = 2'b00;

  // Bits needed to hold round indices 0..r; never less than one.
  function automatic int cnt_width(input int r);
    return (r < 1) ? 1 : $clog2(r + 1);
  endfunction

endpackage

// File: rtl/prince_round_ctrl_if.sv
// Handshake bundle between the requester and the round controller.
//   st, dec_i     : start strobe and mode (requester -> controller)
//   hold          : freeze, only with PRINCE_ROUND_CTRL_HOLD_EN defined
//   act, s, cnt   : datapath active, phase select, first round index
//   dec, done     : latched mode, one-cycle completion pulse
// Modports: master = requester side, slave = controller side.
interface prince_round_ctrl_if #(
  parameter int CW = 3
) ();

  logic          st;
  logic          dec_i;
`ifdef PRINCE_ROUND_CTRL_HOLD_EN
  logic          hold;
`endif
  logic          act;
  logic [1:0]    s;
  logic [CW-1:0] cnt;
  logic          dec;
  logic          done;

  modport master (
    output st, dec_i,
`ifdef PRINCE_ROUND_CTRL_HOLD_EN
    output hold,
`endif
    input  act, s, cnt, dec, done
  );

  modport slave (
    input  st, dec_i,
`ifdef PRINCE_ROUND_CTRL_HOLD_EN
    input  hold,
`endif
    output act, s, cnt, dec, done
  );

endinterface

// File: rtl/prince_round_ctrl_rnd_cnt.sv
// prince_rnd_cnt: loadable up/down round counter stepping by U.
//   clk, rst : clock, synchronous active-high reset (clears to 0)
//   ld       : load ld_val (priority over up/dn)
//   up, dn   : step by +U / -U
//   cnt      : current round index
//   at_top   : cnt + U > R, the forward phase ends this cycle
//   at_zero  : cnt == 0, the backward phase ends this cycle
module prince_rnd_cnt #(
  parameter int R  = 4,
  parameter int U  = 1,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          up,
  input  logic          dn,
  output logic [CW-1:0] cnt,
  output logic          at_top,
  output logic          at_zero
);

  // One extra bit so cnt + U cannot overflow when U equals R+1.
  assign at_top  = ({1'b0, cnt} + (CW + 1)'(U)) > (CW + 1)'(R);
  assign at_zero = (cnt == '0);

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst)     cnt <= '0;
    else if (ld) cnt <= ld_val;
    else if (up) cnt <= cnt + CW'(U);
    else if (dn) cnt <= cnt - CW'(U);
  end

endmodule

// File: rtl/prince_round_ctrl.sv
// prince_round_ctrl: sequences the round-based Prince datapath through a
// forward phase (indices 0..R, U per clock), one middle cycle and a backward
// phase (R+1-U down to 0), then pulses done for one cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : prince_round_ctrl_if.slave (st, dec_i, [hold], act, s, cnt,
//              dec, done)
// Optional: define PRINCE_ROUND_CTRL_HOLD_EN to add the hold/freeze input.
module prince_round_ctrl
  import prince_pkg::*;
#(
  parameter int R  = 4,
  parameter int U  = 1,
  parameter int CW = cnt_width(R)
) (
  input  logic                clk,
  input  logic                rst,
  prince_round_ctrl_if.slave  bus
);

  if (U < 1 || ((R + 1) % U) != 0) begin : g_bad_cfg
    $error("prince_round_ctrl: (R+1) must be a positive multiple of U");
  end

  // U == R+1 skips the forward state entirely, so U may not fit in CW bits.
  localparam logic [CW-1:0] FWD_START = (U == R + 1) ? '0 : CW'(U);
  localparam logic [CW-1:0] BWD_START = CW'(R + 1 - U);
  localparam state_e        ST_NEXT   = (U == R + 1) ? MID : FWD;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_o, ld_val;
  logic          ld, up, dn, at_top, at_zero;
  logic          done_set, done_q, dec_q, hold_w, act_o;
  logic [1:0]    sel_o;

`ifdef PRINCE_ROUND_CTRL_HOLD_EN
  assign hold_w = bus.hold;
`else
  assign hold_w = 1'b0;
`endif

  prince_rnd_cnt #(.R(R), .U(U), .CW(CW)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .ld_val  (ld_val),
    .up      (up),
    .dn      (dn),
    .cnt     (cnt_q),
    .at_top  (at_top),
    .at_zero (at_zero)
  );

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    ld       = 1'b0;
    ld_val   = '0;
    up       = 1'b0;
    dn       = 1'b0;
    done_set = 1'b0;
    act_o    = 1'b0;
    sel_o    = SEL_BWD;
    cnt_o    = '0;

    unique case (state_q)
      IDLE: ;
      FWD: begin
        act_o = 1'b1;
        sel_o = SEL_FWD;
        cnt_o = cnt_q;
        if (at_top) state_d = MID;
        else        up      = 1'b1;
      end
      MID: begin
        act_o   = 1'b1;
        sel_o   = SEL_MID;
        state_d = BWD;
        ld      = 1'b1;
        ld_val  = BWD_START;
      end
      BWD: begin
        act_o = 1'b1;
        cnt_o = cnt_q;
        if (at_zero) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end else begin
          dn = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Freeze: outputs keep showing the held state, nothing advances.
    if (hold_w) begin
      state_d  = state_q;
      ld       = 1'b0;
      up       = 1'b0;
      dn       = 1'b0;
      done_set = 1'b0;
    end

    // Start or restart from any state; the aborted run never reports done.
    if (bus.st) begin
      act_o    = 1'b1;
      sel_o    = SEL_FWD;
      cnt_o    = '0;
      state_d  = ST_NEXT;
      ld       = 1'b1;
      ld_val   = FWD_START;
      up       = 1'b0;
      dn       = 1'b0;
      done_set = 1'b0;
    end

    if (rst) begin
      act_o    = 1'b0;
      sel_o    = SEL_BWD;
      cnt_o    = '0;
      state_d  = IDLE;
      done_set = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_set;
      if (bus.st) dec_q <= bus.dec_i;
    end
  end

  assign bus.act  = act_o;
  assign bus.s    = sel_o;
  assign bus.cnt  = cnt_o;
  assign bus.dec  = dec_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_prince_round_ctrl.sv
// Directed bench for prince_round_ctrl: three configurations (R=4/U=1,
// R=5/U=2, R=4/U=5) share clock and reset; one is selected per scenario and
// its outputs compared cycle by cycle against hand-written sequences.
module tb_prince_round_ctrl;

  localparam int K_A     = 0;  // defaults, single operation
  localparam int K_RESTART = 1;
  localparam int K_RST   = 2;
  localparam int K_R5    = 3;
  localparam int K_U5    = 4;
  localparam int K_HOLD  = 5;

  typedef struct {
    int act;
    int s;
    int cnt;
    int done;
    int dec;
    bit chk_dec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic st_v, dec_v, hold_v;
  int   sel;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic       o_act, o_done, o_dec;
  logic [1:0] o_s;
  logic [2:0] o_cnt;

  always #5 clk = ~clk;

  prince_round_ctrl_if #(.CW(3)) bus0 ();
  prince_round_ctrl_if #(.CW(3)) bus1 ();
  prince_round_ctrl_if #(.CW(3)) bus2 ();

  assign bus0.st = st_v && (sel == 0);
  assign bus1.st = st_v && (sel == 1);
  assign bus2.st = st_v && (sel == 2);
  assign bus0.dec_i = dec_v;
  assign bus1.dec_i = dec_v;
  assign bus2.dec_i = dec_v;
`ifdef PRINCE_ROUND_CTRL_HOLD_EN
  assign bus0.hold = hold_v;
  assign bus1.hold = 1'b0;
  assign bus2.hold = 1'b0;
`endif

  prince_round_ctrl #(.R(4), .U(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  prince_round_ctrl #(.R(5), .U(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  prince_round_ctrl #(.R(4), .U(5)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always_comb begin
    o_act = bus0.act; o_s = bus0.s; o_cnt = bus0.cnt; o_dec = bus0.dec; o_done = bus0.done;
    if (sel == 1) begin
      o_act = bus1.act; o_s = bus1.s; o_cnt = bus1.cnt; o_dec = bus1.dec; o_done = bus1.done;
    end else if (sel == 2) begin
      o_act = bus2.act; o_s = bus2.s; o_cnt = bus2.cnt; o_dec = bus2.dec; o_done = bus2.done;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Default configuration: one operation started at cycle j = 0.
  function automatic exp_t base(input int j);
    exp_t e;
    e.cnt     = (j <= 4) ? j : (j == 5) ? 0 : (j <= 10) ? 10 - j : 0;
    e.s       = (j <= 4) ? 3 : (j == 5) ? 2 : 0;
    e.act     = (j <= 10) ? 1 : 0;
    e.done    = (j == 11) ? 1 : 0;
    e.dec     = 1;
    e.chk_dec = (j != 0);
    return e;
  endfunction

  function automatic exp_t expect_at(input int kind, input int k);
    exp_t e;
    int   r5_cnt [9] = '{0, 2, 4, 0, 4, 2, 0, 0, 0};
    int   r5_s   [9] = '{3, 3, 3, 2, 0, 0, 0, 0, 0};
    e = base(k);
    case (kind)
      K_RESTART: begin
        e = base((k < 6) ? k : k - 6);
        e.dec     = (k <= 6) ? 1 : 0;
        e.chk_dec = (k != 0) && (k != 6);
      end
      K_RST: begin
        if (k >= 3) begin
          e.act = 0; e.s = 0; e.cnt = 0; e.done = 0;
        end
        e.dec     = (k < 3) ? 1 : 0;
        e.chk_dec = (k != 0) && (k != 3);
      end
      K_R5: begin
        e.cnt  = r5_cnt[k];
        e.s    = r5_s[k];
        e.act  = (k <= 6) ? 1 : 0;
        e.done = (k == 7) ? 1 : 0;
      end
      K_U5: begin
        e.cnt  = 0;
        e.s    = (k == 0) ? 3 : (k == 1) ? 2 : 0;
        e.act  = (k <= 2) ? 1 : 0;
        e.done = (k == 3) ? 1 : 0;
      end
      K_HOLD: begin
        e = base((k <= 4) ? k : (k <= 7) ? 4 : k - 3);
        e.chk_dec = (k != 0);
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run(input string tag, input int kind, input int dut, input int n);
    exp_t e;
    sel = dut;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      st_v   = (k == 0) || (kind == K_RESTART && k == 6) || (kind == K_RST && k == 3);
      dec_v  = (kind == K_RESTART) ? (k == 0) : 1'b1;
      rst    = (kind == K_RST && k == 3);
      hold_v = (kind == K_HOLD && k >= 4 && k <= 6);
      @(negedge clk);
      e = expect_at(kind, k);
      check($sformatf("%s c%0d act", tag, k), int'(o_act), e.act);
      check($sformatf("%s c%0d s", tag, k), int'(o_s), e.s);
      check($sformatf("%s c%0d cnt", tag, k), int'(o_cnt), e.cnt);
      check($sformatf("%s c%0d done", tag, k), int'(o_done), e.done);
      if (e.chk_dec) check($sformatf("%s c%0d dec", tag, k), int'(o_dec), e.dec);
    end
    @(posedge clk);
    #1;
    st_v = 1'b0; rst = 1'b0; hold_v = 1'b0;
  endtask

  initial begin
    rst = 1'b1; st_v = 1'b0; dec_v = 1'b0; hold_v = 1'b0; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      check($sformatf("reset d%0d act", d), int'(o_act), 0);
      check($sformatf("reset d%0d s", d), int'(o_s), 0);
      check($sformatf("reset d%0d cnt", d), int'(o_cnt), 0);
      check($sformatf("reset d%0d dec", d), int'(o_dec), 0);
      check($sformatf("reset d%0d done", d), int'(o_done), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    run("default", K_A, 0, 13);
    run("restart", K_RESTART, 0, 19);
    run("rst_st", K_RST, 0, 8);
    run("r5u2", K_R5, 1, 9);
    run("u5", K_U5, 2, 5);
`ifdef PRINCE_ROUND_CTRL_HOLD_EN
    run("hold", K_HOLD, 0, 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
